// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: issues pc/ce to instruction
// memory over a req/ack handshake, handles stall, branch, flush and misalignment.
module pc_gen #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
    parameter int unsigned          INC        = 4,
    parameter int unsigned          ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              inst_ack,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_req,
    output logic              addr_err
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        state_t            state;
        logic              ce;
        logic [ADDR_W-1:0] pc;
        logic              pend_valid;
        logic [ADDR_W-1:0] pend_target;
    } regs_t;

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    regs_t cur, nxt;

    // Alignment check; a zero ALIGN_BITS means every address is legal.
    generate
        if (ALIGN_BITS == 0) begin : g_no_align
            assign addr_err = 1'b0;
        end else begin : g_align
            assign addr_err = cur.ce && (cur.pc[ALIGN_BITS-1:0] != '0);
        end
    endgenerate

    assign ce       = cur.ce;
    assign pc       = cur.pc;
    assign inst_req = cur.ce && !addr_err;

    always_comb begin
        nxt = cur;
        unique case (cur.state)
            IDLE: begin
                nxt.state = RUN;
                nxt.ce    = 1'b1;
            end
            RUN: begin
                if (flush) begin
                    nxt.pc         = new_pc;
                    nxt.pend_valid = 1'b0;
                end else if (addr_err || stall || !inst_ack) begin
                    // Fetch blocked: remember the newest branch for later.
                    if (branch_flag) begin
                        nxt.pend_valid  = 1'b1;
                        nxt.pend_target = branch_target;
                    end
                end else begin
                    if (branch_flag)
                        nxt.pc = branch_target;
                    else if (cur.pend_valid)
                        nxt.pc = cur.pend_target;
                    else
                        nxt.pc = cur.pc + INC_V;
                    nxt.pend_valid = 1'b0;
                end
            end
            default: nxt.state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur.state       <= IDLE;
            cur.ce          <= 1'b0;
            cur.pc          <= RESET_VEC;
            cur.pend_valid  <= 1'b0;
            cur.pend_target <= '0;
        end else begin
            cur <= nxt;
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the instruction-fetch stage.
- Drives the fetch address and chip enable to instruction memory through a req/ack handshake.
- Accepts pipeline stall, branch redirect and exception flush.
- Captures a branch that arrives while the fetch is blocked and applies it when the fetch completes. Flags misaligned fetch addresses.

Parameters:
ADDR_W, 32, width of pc, branch_target and new_pc
RESET_VEC, 0, pc value held during and after reset until the first advance
INC, 4, byte increment per sequential instruction
ALIGN_BITS, 2, number of low pc bits that must be zero for a legal fetch

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  pipeline stall, holds pc
branch_flag  input  1  taken branch/jump this cycle
branch_target  input  ADDR_W  branch destination
flush  input  1  exception/eret redirect, highest non-reset priority
new_pc  input  ADDR_W  flush destination
inst_ack  input  1  instruction memory has returned data for current pc
ce  output  1  registered chip enable to instruction memory
pc  output  ADDR_W  registered fetch address
inst_req  output  1  fetch request, equals ce AND NOT addr_err
addr_err  output  1  ce AND (pc[ALIGN_BITS-1:0] != 0)

Behaviour:
- Reset (rst=1 at a clock edge): ce<=0, pc<=RESET_VEC, pend_valid<=0, pend_target<=0, state<=IDLE. Mid-operation reset discards any pending redirect and outstanding fetch. Outputs are valid one edge after reset is sampled.
- States:
  - IDLE: ce=0, pc held at RESET_VEC, all other inputs ignored. IDLE goes to RUN on the first edge with rst=0, with ce<=1 and pc unchanged. The first request is therefore to RESET_VEC.
  - RUN: ce=1. Per-edge priority, highest first:
    1. flush: pc<=new_pc, pend_valid<=0. An inst_ack in the same cycle is ignored and the old fetch is discarded; stall and branch are ignored.
    2. addr_err=1: pc held, inst_req=0. If branch_flag=1, pend captures the branch. Only flush or rst leaves this condition.
    3. stall=1 or inst_ack=0: pc held. If branch_flag=1, pend_valid<=1 and pend_target<=branch_target; the latest branch wins.
    4. inst_ack=1 and stall=0: pc<=branch_target if branch_flag=1, else pend_target if pend_valid=1, else pc+INC. pend_valid<=0.
- Arithmetic: pc+INC is modulo 2^ADDR_W. The all-ones region wraps to 0 with no flag.
- The pc advances at most once per cycle; there are no combinational paths from inputs to pc or ce.
- Latency: redirect inputs affect pc on the next edge.
- inst_req and addr_err are combinational from registered pc and ce only.
- If inst_ack is asserted while inst_req=0, it is ignored.

Test Plan:
- Reset and start: rst=1 for 3 cycles then 0, inst_ack=1, RESET_VEC=0.
  - Required: ce=0 and pc=0 during reset; ce=1 one edge after release with pc=0; then pc=4, 8, 12 on successive edges.
- Stall and ack gaps: stall=1 for 2 cycles at pc=0x10, then inst_ack=0 for 1 cycle.
  - Required: pc stays 0x10 for 3 cycles, then 0x14 on the next acked edge.
- Pending branch: pc=0x20, inst_ack=0, branch_flag=1 with branch_target=0x100 for one cycle, then inst_ack=1.
  - Required: pc holds 0x20, then goes to 0x100. If two branches occur during the wait (0x100 then 0x200), pc goes to 0x200.
- Flush priority: in the same cycle assert stall=1, branch_flag=1 with branch_target=0x40, and flush=1 with new_pc=0x180.
  - Required: pc=0x180 next edge, pend cleared, and the following acked edge gives 0x184.
- Misalign and wrap:
  - Flush with new_pc=0x202 → addr_err=1, inst_req=0, pc holds despite inst_ack. A subsequent flush with new_pc=0x300 clears it.
  - With ADDR_W=8, pc=0xFC, acked → pc=0x00.
- Reset mid-stall: pend_valid=1 and stall=1, then assert rst.
  - Required: pc=RESET_VEC and ce=0; after release the first advance is RESET_VEC+INC, not the old target.
